// File: rtl/tlb_fill_seq_if.sv
// Bundle of the request/refill handshake and the shared TLB way bus
// between the lookup/refill sequencer and its surroundings.
// slave  : the sequencer side (tlb_fill_seq).
// master : the requester plus the two tlbgroup ways.
interface tlb_fill_seq_if;
  // Requester side
  logic        lookup_h;
  logic [22:0] va_h;
  logic        inval_all_h;
  logic        fill_h;
  logic [19:0] fill_pte_h;
  // Way read-back
  logic        hit0_h;
  logic        hit1_h;
  logic        perr0_h;
  logic        perr1_h;
  logic [19:0] data0_h;
  logic [19:0] data1_h;
  // Way address / write bus
  logic [7:0]  index_h;
  logic [14:0] tag_h;
  logic        valid_h;
  logic        tag_par_h;
  logic [19:0] wdata_h;
  logic [2:0]  wpar_h;
  logic        write0_h;
  logic        write1_h;
  // Status back to the requester
  logic        busy_h;
  logic        done_h;
  logic        miss_h;
  logic        perr_h;
  logic [19:0] pte_out_h;

  modport slave (
    input  lookup_h, va_h, inval_all_h, fill_h, fill_pte_h,
    input  hit0_h, hit1_h, perr0_h, perr1_h, data0_h, data1_h,
    output index_h, tag_h, valid_h, tag_par_h, wdata_h, wpar_h,
    output write0_h, write1_h, busy_h, done_h, miss_h, perr_h, pte_out_h
  );

  modport master (
    output lookup_h, va_h, inval_all_h, fill_h, fill_pte_h,
    output hit0_h, hit1_h, perr0_h, perr1_h, data0_h, data1_h,
    input  index_h, tag_h, valid_h, tag_par_h, wdata_h, wpar_h,
    input  write0_h, write1_h, busy_h, done_h, miss_h, perr_h, pte_out_h
  );
endinterface

// File: rtl/tlb_fill_seq.sv
// Lookup / refill sequencer for a two-way, 256-set TLB made of two
// tlbgroup ways. A lookup latches the virtual page, presents index/tag to
// both ways for one cycle and resolves hit, miss or parity/multi-hit error.
// A miss waits for a PTE, writes it into the least-recently-used way and
// retries the lookup. A sweep invalidates every set of both ways.
module tlb_fill_seq (
  input  logic          b_clk_l,
  input  logic          reset_h,
  tlb_fill_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOOK  = 3'd1,
    MISS  = 3'd2,
    FILL  = 3'd3,
    SWEEP = 3'd4
  } state_t;

  state_t       state;
  logic [22:0]  va_lat;     // latched virtual page number
  logic [7:0]   sweep_cnt;  // set currently being invalidated
  logic [255:0] lru;        // per set: way number to replace next
  logic         valid;
  logic [19:0]  wdata;
  logic         write0;
  logic         write1;
  logic         done;
  logic         miss;
  logic         perr;
  logic [19:0]  pte_out;

  logic [7:0]   cur_index;
  logic [14:0]  cur_tag;
  logic         lru_cur;
  logic         any_hit;
  logic         way_err;

  // Address presented to both ways: the sweep counter while sweeping,
  // otherwise the latched page (LOOK compares, FILL writes).
  always_comb begin
    cur_index = va_lat[7:0];
    cur_tag   = va_lat[22:8];
    if (state == SWEEP) begin
      cur_index = sweep_cnt;
      cur_tag   = '0;
    end
  end

  assign lru_cur = lru[va_lat[7:0]];
  assign any_hit = bus.hit0_h | bus.hit1_h;

  // A way reporting a hit with bad tag parity, or both ways hitting at
  // once, means the lookup result cannot be trusted.
  assign way_err = (bus.perr0_h & bus.hit0_h) |
                   (bus.perr1_h & bus.hit1_h) |
                   (bus.hit0_h  & bus.hit1_h);

  assign bus.index_h   = cur_index;
  assign bus.tag_h     = cur_tag;
  assign bus.valid_h   = valid;
  assign bus.tag_par_h = ~^{valid, cur_tag};
  assign bus.wdata_h   = wdata;
  assign bus.wpar_h    = {~^wdata[19:16], ~^wdata[15:8], ~^wdata[7:0]};
  assign bus.write0_h  = write0;
  assign bus.write1_h  = write1;
  assign bus.busy_h    = (state != IDLE);
  assign bus.done_h    = done;
  assign bus.miss_h    = miss;
  assign bus.perr_h    = perr;
  assign bus.pte_out_h = pte_out;

  // Sequencer FSM with all write/status outputs registered so the way
  // write enables are stable for the whole cycle they are asserted.
  always_ff @(posedge b_clk_l or posedge reset_h) begin
    if (reset_h) begin
      state     <= IDLE;
      va_lat    <= '0;
      sweep_cnt <= '0;
      lru       <= '0;
      valid     <= 1'b0;
      wdata     <= '0;
      write0    <= 1'b0;
      write1    <= 1'b0;
      done      <= 1'b0;
      miss      <= 1'b0;
      perr      <= 1'b0;
      pte_out   <= '0;
    end else begin
      done <= 1'b0;
      perr <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.inval_all_h) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            write0    <= 1'b1;
            write1    <= 1'b1;
            valid     <= 1'b0;
            wdata     <= '0;
          end else if (bus.lookup_h) begin
            va_lat <= bus.va_h;
            state  <= LOOK;
          end
        end

        LOOK: begin
          if (way_err) begin
            perr  <= 1'b1;
            state <= IDLE;
          end else if (any_hit) begin
            done                <= 1'b1;
            pte_out             <= bus.hit1_h ? bus.data1_h : bus.data0_h;
            // The other way becomes the replacement candidate.
            lru[va_lat[7:0]]    <= ~bus.hit1_h;
            state               <= IDLE;
          end else begin
            miss  <= 1'b1;
            state <= MISS;
          end
        end

        MISS: begin
          if (bus.inval_all_h) begin
            // Sweep wins; the pending refill is dropped.
            miss      <= 1'b0;
            state     <= SWEEP;
            sweep_cnt <= '0;
            write0    <= 1'b1;
            write1    <= 1'b1;
            valid     <= 1'b0;
            wdata     <= '0;
          end else if (bus.fill_h) begin
            miss   <= 1'b0;
            wdata  <= bus.fill_pte_h;
            valid  <= 1'b1;
            write0 <= ~lru_cur;
            write1 <= lru_cur;
            state  <= FILL;
          end
        end

        FILL: begin
          write0           <= 1'b0;
          write1           <= 1'b0;
          valid            <= 1'b0;
          wdata            <= '0;
          lru[va_lat[7:0]] <= ~lru_cur;
          state            <= LOOK;
        end

        SWEEP: begin
          if (sweep_cnt == 8'd255) begin
            sweep_cnt <= '0;
            lru       <= '0;
            write0    <= 1'b0;
            write1    <= 1'b0;
            state     <= IDLE;
          end else begin
            sweep_cnt <= sweep_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_fill_seq.sv
// Bench for tlb_fill_seq: two behavioural TLB ways respond to the DUT's
// address/write bus, and a set-level reference model (contents + LRU per
// set) predicts every hit, miss, fill way and returned PTE.
module tb_tlb_fill_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tlb_fill_seq_if tif ();

  tlb_fill_seq dut (
    .b_clk_l (clk),
    .reset_h (rst),
    .bus     (tif)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural TLB ways, written by the DUT's write enables.
  logic        wm_valid [2][256];
  logic [14:0] wm_tag   [2][256];
  logic [19:0] wm_data  [2][256];
  logic force_hit0 = 1'b0, force_hit1 = 1'b0;
  logic force_perr0 = 1'b0, force_perr1 = 1'b0;

  // Way model storage update at end of each write cycle.
  always @(posedge clk) begin
    if (tif.write0_h) begin
      wm_valid[0][tif.index_h] <= tif.valid_h;
      wm_tag[0][tif.index_h]   <= tif.tag_h;
      wm_data[0][tif.index_h]  <= tif.wdata_h;
    end
    if (tif.write1_h) begin
      wm_valid[1][tif.index_h] <= tif.valid_h;
      wm_tag[1][tif.index_h]   <= tif.tag_h;
      wm_data[1][tif.index_h]  <= tif.wdata_h;
    end
  end

  assign tif.hit0_h  = force_hit0 | ((wm_valid[0][tif.index_h] === 1'b1) && (wm_tag[0][tif.index_h] == tif.tag_h));
  assign tif.hit1_h  = force_hit1 | ((wm_valid[1][tif.index_h] === 1'b1) && (wm_tag[1][tif.index_h] == tif.tag_h));
  assign tif.perr0_h = force_perr0;
  assign tif.perr1_h = force_perr1;
  assign tif.data0_h = wm_data[0][tif.index_h];
  assign tif.data1_h = wm_data[1][tif.index_h];

  // Reference model of the TLB at the set level.
  bit          ref_valid [2][256];
  logic [14:0] ref_tag   [2][256];
  logic [19:0] ref_data  [2][256];
  bit [255:0]  ref_lru;
  logic [19:0] last_pte;

  task automatic ref_clear_sets(input int upto);
    for (int s = 0; s < upto; s++) begin
      ref_valid[0][s] = 1'b0;
      ref_valid[1][s] = 1'b0;
    end
  endtask

  task automatic test_reset;
    tif.lookup_h = 1'b1; tif.va_h = 23'h7fffff; tif.inval_all_h = 1'b0;
    tif.fill_h = 1'b1; tif.fill_pte_h = 20'hfffff;
    #1 rst = 1'b1;
    #20;
    checks++;
    if ({tif.busy_h, tif.done_h, tif.miss_h, tif.perr_h, tif.write0_h, tif.write1_h, tif.valid_h} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got=%b want=0000000", {tif.busy_h, tif.done_h, tif.miss_h, tif.perr_h, tif.write0_h, tif.write1_h, tif.valid_h});
    end
    checks++;
    if (tif.index_h !== 8'h0 || tif.tag_h !== 15'h0 || tif.wdata_h !== 20'h0 || tif.pte_out_h !== 20'h0) begin
      errors++; $display("FAIL reset_bus got idx=%h tag=%h wdata=%h pte=%h want all 0", tif.index_h, tif.tag_h, tif.wdata_h, tif.pte_out_h);
    end
    checks++;
    if (tif.tag_par_h !== 1'b1 || tif.wpar_h !== 3'b111) begin
      errors++; $display("FAIL reset_parity got tp=%b wp=%b want tp=1 wp=111", tif.tag_par_h, tif.wpar_h);
    end
    tif.lookup_h = 1'b0; tif.fill_h = 1'b0; tif.va_h = '0; tif.fill_pte_h = '0;
    @(negedge clk); rst = 1'b0;
    ref_lru = '0; last_pte = '0; ref_clear_sets(256);
  endtask

  // Full invalidate sweep; from_miss checks the abandoned-miss case.
  task automatic test_sweep(input bit from_miss);
    @(negedge clk); tif.inval_all_h = 1'b1;
    @(negedge clk); tif.inval_all_h = 1'b0;
    if (from_miss) begin
      checks++;
      if (tif.miss_h !== 1'b0) begin errors++; $display("FAIL sweep_miss_drop got=%b want=0", tif.miss_h); end
    end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (tif.busy_h !== 1'b1 || tif.write0_h !== 1'b1 || tif.write1_h !== 1'b1 || tif.index_h !== i[7:0] ||
          tif.valid_h !== 1'b0 || tif.tag_h !== 15'h0 || tif.wdata_h !== 20'h0 || tif.tag_par_h !== 1'b1 || tif.wpar_h !== 3'b111) begin
        errors++;
        $display("FAIL sweep_cycle%0d got busy=%b w0=%b w1=%b idx=%h v=%b tag=%h wd=%h tp=%b wp=%b want 1 1 1 %h 0 0 0 1 111",
                 i, tif.busy_h, tif.write0_h, tif.write1_h, tif.index_h, tif.valid_h, tif.tag_h, tif.wdata_h, tif.tag_par_h, tif.wpar_h, i[7:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (tif.busy_h !== 1'b0 || tif.write0_h !== 1'b0 || tif.write1_h !== 1'b0) begin
      errors++; $display("FAIL sweep_end got busy=%b w0=%b w1=%b want 0 0 0", tif.busy_h, tif.write0_h, tif.write1_h);
    end
    ref_clear_sets(256); ref_lru = '0;
    $display("sweep done from_miss=%0d", from_miss);
  endtask

  // One lookup; on a miss, refill and retry. way_used=-1 on a direct hit.
  task automatic lookup_and_fill(input logic [22:0] va, input logic [19:0] pte, output int way_used);
    logic [7:0] idx; logic [14:0] tg; int hw; int fw;
    idx = va[7:0]; tg = va[22:8]; hw = -1; way_used = -1;
    for (int w = 0; w < 2; w++) if (ref_valid[w][idx] && ref_tag[w][idx] == tg) hw = w;
    @(negedge clk); tif.lookup_h = 1'b1; tif.va_h = va;
    @(negedge clk); tif.lookup_h = 1'b0; tif.va_h = 23'($urandom);
    checks++;
    if (tif.busy_h !== 1'b1 || tif.index_h !== idx || tif.tag_h !== tg) begin
      errors++; $display("FAIL look_addr got busy=%b idx=%h tag=%h want 1 %h %h", tif.busy_h, tif.index_h, tif.tag_h, idx, tg);
    end
    @(negedge clk);
    if (hw >= 0) begin
      checks++;
      if (tif.done_h !== 1'b1 || tif.miss_h !== 1'b0 || tif.perr_h !== 1'b0 || tif.pte_out_h !== ref_data[hw][idx]) begin
        errors++; $display("FAIL hit_result va=%h got done=%b miss=%b perr=%b pte=%h want 1 0 0 %h", va, tif.done_h, tif.miss_h, tif.perr_h, tif.pte_out_h, ref_data[hw][idx]);
      end
      ref_lru[idx] = (hw == 0);
      last_pte = ref_data[hw][idx];
      $display("lookup va=%h hit way%0d pte=%h", va, hw, tif.pte_out_h);
    end else begin
      checks++;
      if (tif.miss_h !== 1'b1 || tif.done_h !== 1'b0 || tif.busy_h !== 1'b1 || tif.pte_out_h !== last_pte) begin
        errors++; $display("FAIL miss_result va=%h got miss=%b done=%b busy=%b pte=%h want 1 0 1 %h", va, tif.miss_h, tif.done_h, tif.busy_h, tif.pte_out_h, last_pte);
      end
      // A lookup presented while waiting must be ignored.
      tif.fill_h = 1'b1; tif.fill_pte_h = pte; tif.lookup_h = 1'b1; tif.va_h = va ^ 23'h1;
      @(negedge clk); tif.fill_h = 1'b0; tif.lookup_h = 1'b0;
      fw = ref_lru[idx] ? 1 : 0;
      checks++;
      if (tif.write0_h !== (fw == 0) || tif.write1_h !== (fw == 1) || tif.index_h !== idx || tif.tag_h !== tg ||
          tif.valid_h !== 1'b1 || tif.wdata_h !== pte || tif.miss_h !== 1'b0) begin
        errors++; $display("FAIL fill_write va=%h got w0=%b w1=%b idx=%h tag=%h v=%b wd=%h miss=%b want way%0d %h %h 1 %h 0",
                           va, tif.write0_h, tif.write1_h, tif.index_h, tif.tag_h, tif.valid_h, tif.wdata_h, tif.miss_h, fw, idx, tg, pte);
      end
      checks++;
      if (tif.tag_par_h !== ~^{1'b1, tg} || tif.wpar_h !== {~^pte[19:16], ~^pte[15:8], ~^pte[7:0]}) begin
        errors++; $display("FAIL fill_parity got tp=%b wp=%b want tp=%b wp=%b", tif.tag_par_h, tif.wpar_h, ~^{1'b1, tg}, {~^pte[19:16], ~^pte[15:8], ~^pte[7:0]});
      end
      ref_valid[fw][idx] = 1'b1; ref_tag[fw][idx] = tg; ref_data[fw][idx] = pte;
      ref_lru[idx] = (fw == 0);
      @(negedge clk);
      checks++;
      if (tif.write0_h !== 1'b0 || tif.write1_h !== 1'b0 || tif.busy_h !== 1'b1) begin
        errors++; $display("FAIL retry_look got w0=%b w1=%b busy=%b want 0 0 1", tif.write0_h, tif.write1_h, tif.busy_h);
      end
      @(negedge clk);
      checks++;
      if (tif.done_h !== 1'b1 || tif.pte_out_h !== pte || tif.busy_h !== 1'b0) begin
        errors++; $display("FAIL retry_done va=%h got done=%b pte=%h busy=%b want 1 %h 0", va, tif.done_h, tif.pte_out_h, tif.busy_h, pte);
      end
      last_pte = pte;
      way_used = fw;
      $display("lookup va=%h miss, filled way%0d pte=%h", va, fw, pte);
    end
  endtask

  task automatic test_miss_fill;
    int w;
    lookup_and_fill(23'h12345, 20'hABCDE, w);
    checks++;
    if (w !== 0 || last_pte !== 20'hABCDE) begin errors++; $display("FAIL first_fill_way got=%0d pte=%h want 0 abcde", w, last_pte); end
    @(negedge clk);
    checks++;
    if (tif.done_h !== 1'b0 || tif.pte_out_h !== 20'hABCDE) begin
      errors++; $display("FAIL done_pulse_hold got done=%b pte=%h want 0 abcde", tif.done_h, tif.pte_out_h);
    end
  endtask

  task automatic test_lru_ways;
    int w;
    lookup_and_fill(23'h67845, 20'h13579, w);
    checks++; if (w !== 1) begin errors++; $display("FAIL second_fill_way got=%0d want 1", w); end
    lookup_and_fill(23'h67845, 20'h0, w);
    checks++; if (w !== -1) begin errors++; $display("FAIL way1_hit got=%0d want -1", w); end
    lookup_and_fill(23'h22245, 20'h2468a, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL after_hit1_fill got=%0d want 0", w); end
    lookup_and_fill(23'h12345, 20'h55aa5, w);
    checks++; if (w !== 1) begin errors++; $display("FAIL evict_fill got=%0d want 1", w); end
  endtask

  // Lookup with forced way outputs that must abort with perr_h.
  task automatic forced_error_lookup(input logic [22:0] va, input string name);
    @(negedge clk); tif.lookup_h = 1'b1; tif.va_h = va;
    @(negedge clk); tif.lookup_h = 1'b0;
    @(negedge clk);
    checks++;
    if (tif.perr_h !== 1'b1 || tif.done_h !== 1'b0 || tif.miss_h !== 1'b0 || tif.busy_h !== 1'b0 || tif.pte_out_h !== last_pte) begin
      errors++; $display("FAIL %s got perr=%b done=%b miss=%b busy=%b pte=%h want 1 0 0 0 %h", name, tif.perr_h, tif.done_h, tif.miss_h, tif.busy_h, tif.pte_out_h, last_pte);
    end
    @(negedge clk);
    checks++;
    if (tif.perr_h !== 1'b0) begin errors++; $display("FAIL %s_pulse got=%b want 0", name, tif.perr_h); end
    $display("lookup va=%h %s perr observed=%b", va, name, tif.perr_h);
  endtask

  task automatic test_multi_hit;
    int w;
    force_hit0 = 1'b1; force_hit1 = 1'b1;
    forced_error_lookup(23'h00177, "multi_hit");
    force_hit0 = 1'b0; force_hit1 = 1'b0;
    lookup_and_fill(23'h00377, 20'h0f0f0, w);
    checks++; if (w !== 0) begin errors++; $display("FAIL multi_hit_lru got=%0d want 0", w); end
  endtask

  task automatic test_perr1;
    int w;
    force_hit1 = 1'b1; force_perr1 = 1'b1;
    forced_error_lookup(23'h00577, "perr1");
    force_hit1 = 1'b0; force_perr1 = 1'b0;
    lookup_and_fill(23'h00777, 20'h80001, w);
    checks++; if (w !== 1) begin errors++; $display("FAIL perr1_lru got=%0d want 1", w); end
  endtask

  task automatic test_ignored_fill;
    @(negedge clk); tif.fill_h = 1'b1; tif.fill_pte_h = 20'h12121;
    @(negedge clk); tif.fill_h = 1'b0;
    checks++;
    if (tif.busy_h !== 1'b0 || tif.write0_h !== 1'b0 || tif.write1_h !== 1'b0) begin
      errors++; $display("FAIL idle_fill_ignored got busy=%b w0=%b w1=%b want 0 0 0", tif.busy_h, tif.write0_h, tif.write1_h);
    end
    $display("fill in idle ignored busy=%b", tif.busy_h);
  endtask

  task automatic test_random;
    logic [14:0] tags [3];
    logic [7:0]  idxs [2];
    int w;
    tags[0] = 15'($urandom); tags[1] = tags[0] ^ 15'h1; tags[2] = tags[0] ^ 15'h2;
    idxs[0] = 8'h10; idxs[1] = 8'h11;
    for (int n = 0; n < 40; n++)
      lookup_and_fill({tags[$urandom_range(0, 2)], idxs[$urandom_range(0, 1)]}, 20'($urandom), w);
  endtask

  task automatic test_reset_mid_sweep;
    @(negedge clk); tif.inval_all_h = 1'b1;
    @(negedge clk); tif.inval_all_h = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (tif.index_h !== 8'd100 || tif.busy_h !== 1'b1) begin
      errors++; $display("FAIL sweep_at_100 got idx=%0d busy=%b want 100 1", tif.index_h, tif.busy_h);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({tif.busy_h, tif.done_h, tif.miss_h, tif.perr_h, tif.write0_h, tif.write1_h, tif.valid_h} !== 7'b0 ||
        tif.index_h !== 8'h0 || tif.tag_h !== 15'h0 || tif.wdata_h !== 20'h0 || tif.pte_out_h !== 20'h0) begin
      errors++; $display("FAIL mid_sweep_reset got flags=%b idx=%h tag=%h wd=%h pte=%h want all 0",
                         {tif.busy_h, tif.done_h, tif.miss_h, tif.perr_h, tif.write0_h, tif.write1_h, tif.valid_h}, tif.index_h, tif.tag_h, tif.wdata_h, tif.pte_out_h);
    end
    ref_clear_sets(100); ref_lru = '0; last_pte = '0;
    @(negedge clk); rst = 1'b0; tif.lookup_h = 1'b1; tif.va_h = 23'h00032;
    @(negedge clk); tif.lookup_h = 1'b0;
    checks++;
    if (tif.busy_h !== 1'b1 || tif.index_h !== 8'h32) begin
      errors++; $display("FAIL post_reset_accept got busy=%b idx=%h want 1 32", tif.busy_h, tif.index_h);
    end
    @(negedge clk);
    checks++;
    if (tif.miss_h !== 1'b1) begin errors++; $display("FAIL post_reset_miss got=%b want 1", tif.miss_h); end
    $display("reset mid sweep, lookup after reset miss=%b", tif.miss_h);
    test_sweep(1'b1);
  endtask

  initial begin
    tif.lookup_h = 1'b0; tif.va_h = '0; tif.inval_all_h = 1'b0;
    tif.fill_h = 1'b0; tif.fill_pte_h = '0;
    test_reset();
    test_sweep(1'b0);
    test_miss_fill();
    test_lru_ways();
    test_multi_hit();
    test_perr1();
    test_ignored_fill();
    test_random();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
